// File: rtl/echo_mem_scheduler.sv
// Shared single-port delay-line RAM sequencer for the stereo echo.
// Each frame it reads the left tap, writes the left mix, then does the same for the right channel.
module echo_mem_scheduler #(
  parameter int DATALEN = 16,
  parameter int ADDRW   = 14
) (
  input  logic               bclk,
  input  logic               rst_n,
  input  logic               lrclk,
  input  logic               enable,
  input  logic [ADDRW-1:0]   delay,
  input  logic [DATALEN-1:0] left_in,
  input  logic [DATALEN-1:0] right_in,
  output logic [DATALEN-1:0] left_out,
  output logic [DATALEN-1:0] right_out,
  output logic               out_valid,
  output logic               overrun,
  output logic [ADDRW:0]     mem_addr,
  output logic               mem_wren,
  output logic [DATALEN-1:0] mem_wdata,
  input  logic [DATALEN-1:0] mem_rdata
);

  // state | meaning
  // IDLE  | wait for lrclk rising edge, latch inputs on it
  // RD_L  | drive left tap address
  // CAP_L | left tap on mem_rdata, form left mix
  // WR_L  | write left mix at wr_ptr
  // RD_R  | drive right tap address
  // CAP_R | right tap on mem_rdata, form right mix
  // WR_R  | write right mix, load outputs
  // DONE  | out_valid pulse, advance wr_ptr
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_L  = 3'd1;
  localparam logic [2:0] CAP_L = 3'd2;
  localparam logic [2:0] WR_L  = 3'd3;
  localparam logic [2:0] RD_R  = 3'd4;
  localparam logic [2:0] CAP_R = 3'd5;
  localparam logic [2:0] WR_R  = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

  logic [2:0]         state_q, state_d;
  logic               lr_q;
  logic [ADDRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDRW-1:0]   delay_q, delay_d;
  logic               en_q, en_d;
  logic [DATALEN-1:0] lin_q, lin_d, rin_q, rin_d;
  logic [DATALEN-1:0] mix_l_q, mix_l_d, mix_r_q, mix_r_d;
  logic [DATALEN-1:0] left_out_q, left_out_d, right_out_q, right_out_d;
  logic               overrun_q, overrun_d;
  logic               frame_edge;
  logic [ADDRW-1:0]   rd_ptr;

  function automatic logic [DATALEN-1:0] mix_f(input logic signed [DATALEN-1:0] a,
                                               input logic signed [DATALEN-1:0] b);
    return (a >>> 1) + (b >>> 1);
  endfunction

  assign frame_edge = lrclk & ~lr_q;
  // delay==0 means DEPTH frames back, which is wr_ptr itself modulo DEPTH
  assign rd_ptr     = wr_ptr_q - delay_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    delay_d     = delay_q;
    en_d        = en_q;
    lin_d       = lin_q;
    rin_d       = rin_q;
    mix_l_d     = mix_l_q;
    mix_r_d     = mix_r_q;
    left_out_d  = left_out_q;
    right_out_d = right_out_q;
    overrun_d   = overrun_q | (frame_edge & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (frame_edge) begin
          lin_d   = left_in;
          rin_d   = right_in;
          delay_d = delay;
          en_d    = enable;
          state_d = RD_L;
        end
      end
      RD_L:  state_d = CAP_L;
      CAP_L: begin
        mix_l_d = mix_f(lin_q, mem_rdata);
        state_d = WR_L;
      end
      WR_L:  state_d = RD_R;
      RD_R:  state_d = CAP_R;
      CAP_R: begin
        mix_r_d = mix_f(rin_q, mem_rdata);
        state_d = WR_R;
      end
      WR_R: begin
        // loaded here so the new samples are present during the out_valid pulse
        left_out_d  = en_q ? mix_l_q : lin_q;
        right_out_d = en_q ? mix_r_q : rin_q;
        state_d     = DONE;
      end
      DONE: begin
        if (en_q) wr_ptr_d = wr_ptr_q + ADDRW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wren  = 1'b0;
    mem_wdata = '0;
    case (state_q)
      RD_L: mem_addr = {1'b0, rd_ptr};
      WR_L: begin
        mem_addr  = {1'b0, wr_ptr_q};
        mem_wren  = en_q;
        mem_wdata = en_q ? mix_l_q : '0;
      end
      RD_R: mem_addr = {1'b1, rd_ptr};
      WR_R: begin
        mem_addr  = {1'b1, wr_ptr_q};
        mem_wren  = en_q;
        mem_wdata = en_q ? mix_r_q : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge bclk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lr_q        <= 1'b1;
      wr_ptr_q    <= '0;
      delay_q     <= '0;
      en_q        <= 1'b0;
      lin_q       <= '0;
      rin_q       <= '0;
      mix_l_q     <= '0;
      mix_r_q     <= '0;
      left_out_q  <= '0;
      right_out_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lr_q        <= lrclk;
      wr_ptr_q    <= wr_ptr_d;
      delay_q     <= delay_d;
      en_q        <= en_d;
      lin_q       <= lin_d;
      rin_q       <= rin_d;
      mix_l_q     <= mix_l_d;
      mix_r_q     <= mix_r_d;
      left_out_q  <= left_out_d;
      right_out_q <= right_out_d;
      overrun_q   <= overrun_d;
    end
  end

  assign left_out  = left_out_q;
  assign right_out = right_out_q;
  assign out_valid = (state_q == DONE);
  assign overrun   = overrun_q;

endmodule
